// File: rtl/vram_arbiter_pkg.sv
// rtl/vram_arbiter_pkg.sv - shared constants and slicing helpers for the VRAM arbiter
//
// Contents:
//   REQ_HOST    index of the strict-priority host requester
//   RD_LATENCY  grant-to-rvalid latency of a read, in cycles
//   idx_width   width of a requester index for a given requester count
//   addr_lo     low bit of requester i's slice in the flattened address bus
//   data_lo     low bit of requester i's slice in the flattened write-data bus
package vram_arb_pkg;

  localparam int REQ_HOST   = 0;
  localparam int RD_LATENCY = 2;

  // Never returns 0 so a two-requester build still gets a 1-bit index.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int addr_lo(input int idx, input int addr_width);
    return idx * addr_width;
  endfunction

  function automatic int data_lo(input int idx, input int data_width);
    return idx * data_width;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - requester and RAM-side signal bundle for the VRAM arbiter
//
// Requester side: req, we, addr (flattened), wdata (flattened) in;
//                 ack, rvalid (one-hot), rdata out.
// RAM side:       ram_wr_addr, ram_wr_en, ram_wr_data, ram_rd_addr out;
//                 ram_rd_data in.
// Modports: slave = the arbiter, master = requesters plus the dpram.
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 3
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;

  logic [ADDR_WIDTH-1:0]         ram_wr_addr;
  logic                          ram_wr_en;
  logic [DATA_WIDTH-1:0]         ram_wr_data;
  logic [ADDR_WIDTH-1:0]         ram_rd_addr;
  logic [DATA_WIDTH-1:0]         ram_rd_data;

  modport slave (
    input  req, we, addr, wdata, ram_rd_data,
    output ack, rvalid, rdata, ram_wr_addr, ram_wr_en, ram_wr_data, ram_rd_addr
  );

  modport master (
    output req, we, addr, wdata, ram_rd_data,
    input  ack, rvalid, rdata, ram_wr_addr, ram_wr_en, ram_wr_data, ram_rd_addr
  );

endinterface

// File: rtl/vram_arbiter_rr_pick.sv
// rtl/vram_arbiter_rr_pick.sv - combinational round-robin one-hot picker
//
// Ports:
//   req    in  N   request vector
//   ptr    in  IW  first candidate index (must be < N)
//   grant  out N   one-hot grant, first requester at or after ptr (wrapping)
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  unused_tie,
  output logic [N-1:0]  grant
);

  // Scan offsets from farthest to nearest so the nearest hit is the last
  // assignment and therefore the one that survives.
  always_comb begin
    int            idx;
    logic [IW-1:0] pos;
    grant = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      pos = IW'(idx);
      if (req[pos] && !unused_tie[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-grant-per-cycle arbiter sharing one dpram among NUM_REQ requesters
//
// Optional feature macro: VRAM_ARB_ROUND_ROBIN_EN
//   defined   - requester 0 strict priority, 1..NUM_REQ-1 round-robin
//   undefined - fixed priority, lowest index wins
//
// Ports:
//   clk    in   clock for the arbiter and the dpram
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of vram_arbiter_if:
//          req/we/addr/wdata in, ack/rvalid/rdata out (requester side)
//          ram_wr_addr/ram_wr_en/ram_wr_data/ram_rd_addr out, ram_rd_data in
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  vram_arbiter_if.slave    bus
);

  localparam int IW = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]    grant;
  logic                  win_any;
  logic [IW-1:0]         win_idx;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  tag_v   [RD_LATENCY];
  logic [IW-1:0]         tag_idx [RD_LATENCY];
  logic [NUM_REQ-1:0]    rvalid_vec;

`ifdef VRAM_ARB_ROUND_ROBIN_EN
  localparam logic [NUM_REQ-1:0] HOST_MASK = NUM_REQ'(1) << REQ_HOST;

  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] rr_grant;

  // Host bit is masked out so the picker only rotates over renderer ports.
  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req        (bus.req),
    .ptr        (rr_ptr),
    .unused_tie (HOST_MASK),
    .grant      (rr_grant)
  );

  always_comb begin
    grant = rr_grant;
    if (bus.req[REQ_HOST]) grant = HOST_MASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= IW'(1);
    end else if (win_any && int'(win_idx) != REQ_HOST) begin
      if (int'(win_idx) == NUM_REQ - 1) rr_ptr <= IW'(1);
      else                              rr_ptr <= win_idx + IW'(1);
    end
  end
`else
  always_comb begin
    grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
`endif

  // Mux the winning requester's command fields.
  always_comb begin
    win_idx   = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_idx   = IW'(i);
        win_we    = bus.we[i];
        win_addr  = bus.addr[addr_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
        win_wdata = bus.wdata[data_lo(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  assign win_any = |grant;

  // ack is forced low while reset is held so nothing is granted into a
  // pipeline that is being cleared.
  assign bus.ack = rst_n ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        tag_v[s]   <= 1'b0;
        tag_idx[s] <= '0;
      end
    end else begin
      wr_en_q <= win_any & win_we;
      if (win_any && win_we) begin
        wr_addr_q <= win_addr;
        wr_data_q <= win_wdata;
      end
      if (win_any && !win_we) rd_addr_q <= win_addr;
      // Tag stage 0 lines up with the address at the RAM, the last stage
      // with the data coming out of the registered read port.
      tag_v[0]   <= win_any & ~win_we;
      tag_idx[0] <= win_idx;
      for (int s = 1; s < RD_LATENCY; s++) begin
        tag_v[s]   <= tag_v[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
    end
  end

  always_comb begin
    rvalid_vec = '0;
    if (tag_v[RD_LATENCY-1]) rvalid_vec[tag_idx[RD_LATENCY-1]] = 1'b1;
  end

  assign bus.rvalid      = rvalid_vec;
  assign bus.rdata       = bus.ram_rd_data;
  assign bus.ram_wr_en   = wr_en_q;
  assign bus.ram_wr_addr = wr_addr_q;
  assign bus.ram_wr_data = wr_data_q;
  assign bus.ram_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter with a behavioural dpram
module tb_vram_arbiter;

  localparam int AW  = 15;
  localparam int DW  = 32;
  localparam int NUM = 3;
`ifdef VRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst_n;

  vram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NUM)) bus ();

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NUM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dpram: write at the edge, registered read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    bus.ram_rd_data <= mem[bus.ram_rd_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state
  typedef struct { int due; int idx; logic [DW-1:0] data; } rd_t;
  rd_t           rdq [$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_ptr;
  int            cyc;
  bit            exp_wr_en;
  logic [AW-1:0] exp_wr_addr;
  logic [DW-1:0] exp_wr_data;

  // Pending requester commands (held until ack)
  bit            p_req   [NUM];
  bit            p_we    [NUM];
  logic [AW-1:0] p_addr  [NUM];
  logic [DW-1:0] p_wdata [NUM];

  logic [NUM-1:0] obs_ack;
  logic [NUM-1:0] obs_rvalid;
  logic [DW-1:0]  obs_rdata;

  function automatic int model_pick();
    if (p_req[0]) return 0;
    if (RR) begin
      for (int k = 0; k < NUM - 1; k++) begin
        int i;
        i = 1 + ((m_ptr - 1 + k) % (NUM - 1));
        if (p_req[i]) return i;
      end
    end else begin
      for (int i = 1; i < NUM; i++) if (p_req[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < NUM; i++) if (p_req[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM; i++) begin
      bus.req[i]              = p_req[i];
      bus.we[i]               = p_we[i];
      bus.addr[i*AW +: AW]    = p_addr[i];
      bus.wdata[i*DW +: DW]   = p_wdata[i];
    end
  endtask

  task automatic post(input int i, input bit w, input int a, input logic [DW-1:0] d);
    p_req[i] = 1'b1; p_we[i] = w; p_addr[i] = AW'(a); p_wdata[i] = d;
  endtask

  // One clock cycle: called at posedge+1, returns at the next posedge+1.
  task automatic cycle();
    int             w;
    logic [NUM-1:0] ea;
    logic [NUM-1:0] erv;
    logic [DW-1:0]  erd;
    drive();
    @(negedge clk);
    w  = model_pick();
    ea = (w >= 0) ? NUM'(1 << w) : '0;
    check(bus.ack == ea, "ack", bus.ack, ea);
    erv = '0;
    erd = '0;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      erv = NUM'(1 << rdq[0].idx);
      erd = rdq[0].data;
      void'(rdq.pop_front());
    end
    check(bus.rvalid == erv, "rvalid", bus.rvalid, erv);
    if (erv != 0) check(bus.rdata == erd, "rdata", bus.rdata, erd);
    check(bus.ram_wr_en == exp_wr_en, "ram_wr_en", bus.ram_wr_en, exp_wr_en);
    if (exp_wr_en) begin
      check(bus.ram_wr_addr == exp_wr_addr, "ram_wr_addr", bus.ram_wr_addr, exp_wr_addr);
      check(bus.ram_wr_data == exp_wr_data, "ram_wr_data", bus.ram_wr_data, exp_wr_data);
    end
    obs_ack    = bus.ack;
    obs_rvalid = bus.rvalid;
    obs_rdata  = bus.rdata;
    exp_wr_en  = 1'b0;
    if (w >= 0) begin
      if (p_we[w]) begin
        ref_mem[p_addr[w]] = p_wdata[w];
        exp_wr_en   = 1'b1;
        exp_wr_addr = p_addr[w];
        exp_wr_data = p_wdata[w];
      end else begin
        rdq.push_back('{due: cyc + 2, idx: w, data: ref_mem[p_addr[w]]});
      end
      if (w != 0) m_ptr = (w == NUM - 1) ? 1 : w + 1;
      p_req[w] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Assert reset (at posedge+1) for ncyc cycles; every output must read 0.
  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    rdq.delete();
    exp_wr_en = 1'b0;
    m_ptr     = 1;
    repeat (ncyc) begin
      drive();
      @(negedge clk);
      check(bus.ack == '0,         "rst_ack",     bus.ack, 0);
      check(bus.rvalid == '0,      "rst_rvalid",  bus.rvalid, 0);
      check(bus.ram_wr_en == 1'b0, "rst_wr_en",   bus.ram_wr_en, 0);
      check(bus.ram_wr_addr == '0, "rst_wr_addr", bus.ram_wr_addr, 0);
      check(bus.ram_wr_data == '0, "rst_wr_data", bus.ram_wr_data, 0);
      check(bus.ram_rd_addr == '0, "rst_rd_addr", bus.ram_rd_addr, 0);
      @(posedge clk);
      #1;
      cyc++;
    end
    rst_n = 1'b1;
  endtask

  typedef struct { logic [NUM-1:0] req; logic [NUM-1:0] ack_fp; logic [NUM-1:0] ack_rr; } vec_t;
  vec_t tbl [18];

  logic [15:0] sh;

  initial begin
    rst_n = 1'b0;
    cyc   = 0;
    m_ptr = 1;
    exp_wr_en = 1'b0;
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a]     = '0;
      ref_mem[a] = '0;
    end
    for (int i = 0; i < NUM; i++) begin
      p_req[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
    end
    drive();
    @(posedge clk);
    #1;
    do_reset(3);

    // Arbitration table, writes only, applied straight after reset (pointer = 1).
    for (int r = 0; r < 4; r++) tbl[r] = '{3'b111, 3'b001, 3'b001};
    tbl[4]  = '{3'b110, 3'b010, 3'b010};
    tbl[5]  = '{3'b110, 3'b010, 3'b100};
    tbl[6]  = '{3'b110, 3'b010, 3'b010};
    tbl[7]  = '{3'b110, 3'b010, 3'b100};
    tbl[8]  = '{3'b110, 3'b010, 3'b010};
    tbl[9]  = '{3'b110, 3'b010, 3'b100};
    tbl[10] = '{3'b100, 3'b100, 3'b100};
    tbl[11] = '{3'b010, 3'b010, 3'b010};
    tbl[12] = '{3'b000, 3'b000, 3'b000};
    tbl[13] = '{3'b101, 3'b001, 3'b001};
    tbl[14] = '{3'b011, 3'b001, 3'b001};
    tbl[15] = '{3'b110, 3'b010, 3'b100};
    tbl[16] = '{3'b110, 3'b010, 3'b010};
    tbl[17] = '{3'b000, 3'b000, 3'b000};
    for (int r = 0; r < 18; r++) begin
      logic [NUM-1:0] exp_ack;
      exp_ack  = RR ? tbl[r].ack_rr : tbl[r].ack_fp;
      bus.req  = tbl[r].req;
      bus.we   = '1;
      for (int i = 0; i < NUM; i++) begin
        bus.addr[i*AW +: AW]  = AW'(16'h4000 + r * 4 + i);
        bus.wdata[i*DW +: DW] = $urandom;
      end
      @(negedge clk);
      check(bus.ack == exp_ack, $sformatf("tbl_ack[%0d]", r), bus.ack, exp_ack);
      @(posedge clk);
      #1;
      cyc++;
    end
    do_reset(2);

    // Single read: write DEADBEEF via requester 1, read it via requester 2 next cycle.
    post(1, 1'b1, 16'h0123, 32'hDEADBEEF);
    cycle();
    post(2, 1'b0, 16'h0123, '0);
    cycle();
    check(obs_ack == 3'b100, "single_rd_ack", obs_ack, 3'b100);
    cycle();
    cycle();
    check(obs_rvalid == 3'b100, "single_rvalid", obs_rvalid, 3'b100);
    check(obs_rdata == 32'hDEADBEEF, "single_rdata", obs_rdata, 32'hDEADBEEF);

    // Back-to-back reads 0..7 from requester 1 after host fills them.
    for (int k = 0; k < 8; k++) begin
      post(0, 1'b1, k, 32'hA5000000 | k);
      cycle();
    end
    sh = '0;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) post(1, 1'b0, k, '0);
      cycle();
      sh = {sh[14:0], obs_rvalid[1]};
    end
    check(sh[9:0] == 10'b0011111111, "b2b_pulses", sh[9:0], 10'b0011111111);

    // Write then read of the same address on the next cycle.
    post(0, 1'b1, 16'h0020, 32'h12345678);
    cycle();
    post(2, 1'b0, 16'h0020, '0);
    cycle();
    cycle();
    cycle();
    check(obs_rvalid == 3'b100, "raw_rvalid", obs_rvalid, 3'b100);
    check(obs_rdata == 32'h12345678, "raw_rdata", obs_rdata, 32'h12345678);

    // Reset with reads in flight: none of them may come back.
    post(1, 1'b0, 1, '0);
    post(2, 1'b0, 2, '0);
    cycle();
    cycle();
    post(1, 1'b0, 3, '0);
    cycle();
    post(1, 1'b0, 4, '0);
    do_reset(3);
    cycle();
    check(obs_ack == 3'b010, "post_rst_ack", obs_ack, 3'b010);
    repeat (4) cycle();

    // Randomized traffic against the model.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NUM; i++) begin
        if (!p_req[i] && $urandom_range(0, 99) < ((i == 0) ? 20 : 50))
          post(i, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom);
      end
      cycle();
    end
    for (int t = 0; t < 40 && (any_pending() || rdq.size() > 0); t++) cycle();
    check(!any_pending() && rdq.size() == 0, "drain", rdq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one `dpram` instance (single clock, one write port, one registered read port) among NUM_REQ requesters, issuing at most one RAM access per cycle. Requester 0 is the host/CPU port with strict priority. Requesters 1..NUM_REQ-1 are the renderer fetch ports. The block sits between the requesters and the VRAM `dpram`, drives both RAM ports, and returns read data tagged per requester.

## Interface
Parameters:
- ADDR_WIDTH, 15: RAM word-address width; matches the `dpram` ADDR_WIDTH.
- DATA_WIDTH, 32: RAM word width.
- NUM_REQ, 3: number of requesters; legal range 2..8.

Ports:
- clk  in  1  single clock, also drives the `dpram` wr_clk and rd_clk.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  request per requester; held until ack.
- we  in  NUM_REQ  1 = write, 0 = read; held with req.
- addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies slice i.
- wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- ack  out  NUM_REQ  one-hot grant pulse.
- rvalid  out  NUM_REQ  one-hot read-data-valid pulse.
- rdata  out  DATA_WIDTH  read data, meaningful only while rvalid is nonzero.
- ram_wr_addr / ram_wr_en / ram_wr_data  out  ADDR_WIDTH / 1 / DATA_WIDTH  to the `dpram` write port.
- ram_rd_addr  out  ADDR_WIDTH  to the `dpram` read port.
- ram_rd_data  in  DATA_WIDTH  from the `dpram` read port.

## Operation
- Each cycle, pick one winner among the asserted req bits.
  - Requester 0 always wins when requesting.
  - Otherwise, pick among requesters 1..NUM_REQ-1 per the Configuration rule.
- ack[winner] is combinational in the request cycle; at most one ack bit is high.
- The requester drops or changes req/we/addr/wdata only after the cycle in which it sees ack.
- Granted write: register ram_wr_en=1, ram_wr_addr, ram_wr_data; the RAM is written at the following edge.
- Granted read: register ram_rd_addr and the winner index. Two entries of a read-tag pipeline carry the winner index and a valid bit.
- ram_wr_en is 0 in any cycle without a granted write.
- ram_rd_addr holds its last value when no read is granted.
- rdata is ram_rd_data passed through unregistered.
- Reset values: ack=0, rvalid=0, ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, ram_rd_addr=0, tag pipeline cleared, RR pointer=1.
- Reset asserted mid-operation: in-flight reads are discarded, so no rvalid is issued for them. Pending requests are re-arbitrated after reset release.

## Timing
- Cycle N: req sampled, ack high.
- Write: committed to the RAM at the end of cycle N+1.
- Read: address reaches the RAM in N+1; rvalid[i] and rdata are valid in cycle N+2. Fixed latency of 2, fully pipelined, one grant per cycle sustained.
- Read-after-write to the same address, granted in consecutive cycles, returns the new data. The write lands at the end of N+1 and the read samples at the end of N+2.
- Read and write never hit the RAM in the same cycle at the same address, because of the single grant per cycle. The `dpram` no_rw_check style is safe.
- No combinational path from ram_rd_data to ack.

## Configuration
- VRAM_ARB_ROUND_ROBIN_EN defined:
  - Requesters 1..NUM_REQ-1 are served round-robin.
  - A pointer marks the first candidate. After a grant to requester i≥1, pointer = i+1, wrapping NUM_REQ→1.
  - Host grants leave the pointer unchanged.
- Undefined: fixed priority; the lowest index wins. The pointer register is not instantiated.

## Structure
- Package `vram_arb_pkg`:
  - REQ_HOST=0
  - RD_LATENCY=2
  - function for the clog2 index width
  - helpers for slicing flattened address and data
- Sub-module `rr_pick`: combinational one-hot picker given a request vector and a pointer. It is used only under VRAM_ARB_ROUND_ROBIN_EN.

## Test plan
- Reset: assert rst_n=0 mid-stream with reads in flight -> all outputs 0, no rvalid afterwards; after release, first req[1] is acked in the same cycle.
- Single read: write 0xDEADBEEF to 0x0123 via requester 1, then read 0x0123 via requester 2 in the next cycle -> rvalid=3'b100 exactly 2 cycles after the read ack, rdata=0xDEADBEEF.
- Host priority: req=3'b111 held for 4 cycles -> ack=3'b001 every cycle; requesters 1 and 2 are never acked.
- Round-robin (macro defined): req=3'b110 held for 6 cycles -> ack sequence 010,100,010,100,010,100. Macro undefined -> ack=010 for all 6.
- Back-to-back reads: requester 1 streams reads 0x0000..0x0007 -> 8 consecutive rvalid pulses in address order, no bubbles.
- Write/read separation: write on cycle N, read of the same address on N+1 -> new data returned; ram_wr_en is never high in a cycle without a write grant.
